// File: rtl/control.sv
`default_nettype none
// +------------------------------------------------------------------+
// | control: multicycle LC-3 control FSM and the datapath it drives    |
// | Rev 1.0 - initial release                                          |
// +------------------------------------------------------------------+

module reg16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] in_data,
    output logic [15:0] out_data
);
    logic [15:0] data_q, data_d;

    always_comb begin
        data_d = load ? in_data : data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end

    assign out_data = data_q;
endmodule

module lc3_mem (
    input  logic        clk,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data
);
    // Contents survive reset; the MDR provides the read register stage.
    logic [15:0] mem [65536];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wr_data;
    end

    assign rd_data = mem[addr];
endmodule

module lc3_datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_pc,
    input  logic [1:0]  pc_sel,
    input  logic        ld_ir,
    input  logic        ld_mar,
    input  logic [1:0]  mar_sel,
    input  logic        ld_mdr,
    input  logic        mdr_sel,
    input  logic        ld_reg,
    input  logic [1:0]  reg_src,
    input  logic        dr_r7,
    input  logic        ld_cc,
    input  logic        mem_we,
    output logic [15:0] pc_val,
    output logic [15:0] ir_val,
    output logic [2:0]  cc_val
);
    logic [15:0] mar_q, mar_d, mdr_q, mdr_d;
    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];
    logic [2:0]  cc_q, cc_d;
    logic [15:0] pc_d, mem_rd;
    logic [15:0] sext5, sext6, sext9, sext11;
    logic [15:0] base, op2, alu, pc_off9, wdata;
    logic [2:0]  dest;

    reg16   pc  (.clk(clk), .reset(reset), .load(ld_pc), .in_data(pc_d),  .out_data(pc_val));
    reg16   ir  (.clk(clk), .reset(reset), .load(ld_ir), .in_data(mdr_q), .out_data(ir_val));
    lc3_mem mem (.clk(clk), .we(mem_we), .addr(mar_q), .wr_data(mdr_q), .rd_data(mem_rd));

    always_comb begin
        sext5   = {{11{ir_val[4]}},  ir_val[4:0]};
        sext6   = {{10{ir_val[5]}},  ir_val[5:0]};
        sext9   = {{7{ir_val[8]}},   ir_val[8:0]};
        sext11  = {{5{ir_val[10]}},  ir_val[10:0]};
        base    = regs_q[ir_val[8:6]];
        op2     = ir_val[5] ? sext5 : regs_q[ir_val[2:0]];
        pc_off9 = pc_val + sext9;

        case (ir_val[15:12])
            4'b0001: alu = base + op2;
            4'b0101: alu = base & op2;
            default: alu = ~base;
        endcase

        // JSR/JSRR target comes from regs_q, so R7 is read before it is overwritten.
        case (pc_sel)
            2'd0:    pc_d = pc_val + 16'd1;
            2'd1:    pc_d = pc_off9;
            2'd2:    pc_d = base;
            default: pc_d = ir_val[11] ? (pc_val + sext11) : base;
        endcase

        mar_d = mar_q;
        if (ld_mar) begin
            case (mar_sel)
                2'd0:    mar_d = pc_val;
                2'd1:    mar_d = ir_val[14] ? (base + sext6) : pc_off9;
                default: mar_d = mdr_q;
            endcase
        end

        mdr_d = mdr_q;
        if (ld_mdr) mdr_d = mdr_sel ? regs_q[ir_val[11:9]] : mem_rd;

        case (reg_src)
            2'd0:    wdata = alu;
            2'd1:    wdata = mdr_q;
            2'd2:    wdata = pc_off9;
            default: wdata = pc_val;
        endcase

        dest   = dr_r7 ? 3'd7 : ir_val[11:9];
        regs_d = regs_q;
        if (ld_reg) regs_d[dest] = wdata;

        cc_d = cc_q;
        if (ld_cc) cc_d = {wdata[15], wdata == 16'd0, ~wdata[15] & (wdata != 16'd0)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mar_q <= '0;
            mdr_q <= '0;
            cc_q  <= 3'b010;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            mar_q  <= mar_d;
            mdr_q  <= mdr_d;
            cc_q   <= cc_d;
            regs_q <= regs_d;
        end
    end

    assign cc_val = cc_q;
endmodule

module control (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        halted,
    output logic [15:0] pc_out,
    output logic [15:0] ir_out,
    output logic [2:0]  cc_out
);
    typedef enum logic [4:0] {
        S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_BR, S_JMP, S_JSR, S_ALU, S_LEA,
        S_ADDR, S_READ1, S_IND, S_READ2, S_WB,
        S_STMDR, S_WRITE, S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic        ld_pc, ld_ir, ld_mar, ld_mdr, mdr_sel, ld_reg, dr_r7, ld_cc, mem_we;
    logic [1:0]  pc_sel, mar_sel, reg_src;

    lc3_datapath dp (
        .clk(clk), .reset(reset),
        .ld_pc(ld_pc), .pc_sel(pc_sel), .ld_ir(ld_ir),
        .ld_mar(ld_mar), .mar_sel(mar_sel), .ld_mdr(ld_mdr), .mdr_sel(mdr_sel),
        .ld_reg(ld_reg), .reg_src(reg_src), .dr_r7(dr_r7), .ld_cc(ld_cc),
        .mem_we(mem_we),
        .pc_val(pc_out), .ir_val(ir_out), .cc_val(cc_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH1;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ld_pc   = 1'b0;  pc_sel  = 2'd0;
        ld_ir   = 1'b0;
        ld_mar  = 1'b0;  mar_sel = 2'd0;
        ld_mdr  = 1'b0;  mdr_sel = 1'b0;
        ld_reg  = 1'b0;  reg_src = 2'd0;  dr_r7 = 1'b0;
        ld_cc   = 1'b0;
        mem_we  = 1'b0;

        case (state_q)
            S_FETCH1: if (run) begin
                ld_mar  = 1'b1;
                ld_pc   = 1'b1;
                state_d = S_FETCH2;
            end
            S_FETCH2: begin ld_mdr = 1'b1; state_d = S_FETCH3; end
            S_FETCH3: begin ld_ir  = 1'b1; state_d = S_DECODE; end
            S_DECODE: begin
                case (ir_out[15:12])
                    4'b0000:                   state_d = S_BR;
                    4'b0001, 4'b0101, 4'b1001: state_d = S_ALU;
                    4'b1100:                   state_d = S_JMP;
                    4'b0100:                   state_d = S_JSR;
                    4'b1110:                   state_d = S_LEA;
                    4'b0010, 4'b0110, 4'b1010,
                    4'b0011, 4'b0111, 4'b1011: state_d = S_ADDR;
                    default:                   state_d = S_HALT;
                endcase
            end
            S_BR: begin
                ld_pc   = |(ir_out[11:9] & cc_out);
                pc_sel  = 2'd1;
                state_d = S_FETCH1;
            end
            S_JMP: begin ld_pc = 1'b1; pc_sel = 2'd2; state_d = S_FETCH1; end
            S_JSR: begin
                ld_pc   = 1'b1;  pc_sel  = 2'd3;
                ld_reg  = 1'b1;  reg_src = 2'd3;  dr_r7 = 1'b1;
                state_d = S_FETCH1;
            end
            S_ALU: begin ld_reg = 1'b1; ld_cc = 1'b1; state_d = S_FETCH1; end
            S_LEA: begin ld_reg = 1'b1; reg_src = 2'd2; state_d = S_FETCH1; end
            // IR[12] marks stores, IR[15] marks the indirect forms (LDI/STI).
            S_ADDR: begin
                ld_mar  = 1'b1;  mar_sel = 2'd1;
                state_d = (ir_out[12] && !ir_out[15]) ? S_STMDR : S_READ1;
            end
            S_READ1: begin ld_mdr = 1'b1; state_d = ir_out[15] ? S_IND : S_WB; end
            S_IND: begin
                ld_mar  = 1'b1;  mar_sel = 2'd2;
                state_d = ir_out[12] ? S_STMDR : S_READ2;
            end
            S_READ2: begin ld_mdr = 1'b1; state_d = S_WB; end
            S_WB: begin
                ld_reg  = 1'b1;  reg_src = 2'd1;  ld_cc = 1'b1;
                state_d = S_FETCH1;
            end
            S_STMDR: begin ld_mdr = 1'b1; mdr_sel = 1'b1; state_d = S_WRITE; end
            S_WRITE: begin mem_we = 1'b1; state_d = S_FETCH1; end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH1;
        endcase
    end

    assign halted = (state_q == S_HALT);
endmodule
`default_nettype wire

// File: tb/tb_control.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_control: directed vector table plus reset/run/halt sequences    |
// | Rev 1.0 - initial release                                          |
// +------------------------------------------------------------------+
module tb_control;
    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        halted;
    logic [15:0] pc_out, ir_out;
    logic [2:0]  cc_out;

    int checks   = 0;
    int failures = 0;

    control dut (
        .clk(clk), .reset(reset), .run(run), .halted(halted),
        .pc_out(pc_out), .ir_out(ir_out), .cc_out(cc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] p0, p1, p2, p3;
        int          a0;
        logic [15:0] v0;
        int          a1;
        logic [15:0] v1;
        int          cycles;
        logic [15:0] pc, ir;
        logic [2:0]  cc;
        logic        halt;
        int          ridx;
        logic [15:0] rval;
        int          maddr;
        logic [15:0] mval;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string name,
                                input logic [15:0] p0, p1, p2, p3,
                                input int a0, input logic [15:0] v0,
                                input int a1, input logic [15:0] v1,
                                input int cycles,
                                input logic [15:0] pc, ir, input logic [2:0] cc, input logic halt,
                                input int ridx, input logic [15:0] rval,
                                input int maddr, input logic [15:0] mval);
        vec_t v;
        v.name = name; v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3;
        v.a0 = a0; v.v0 = v0; v.a1 = a1; v.v1 = v1; v.cycles = cycles;
        v.pc = pc; v.ir = ir; v.cc = cc; v.halt = halt;
        v.ridx = ridx; v.rval = rval; v.maddr = maddr; v.mval = mval;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds the core in reset and clears low memory; caller preloads, then calls go().
    task automatic hold_reset();
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 64; i++) dut.dp.mem.mem[16'(i)] = 16'h0000;
    endtask

    task automatic load_prog(input logic [15:0] p0, p1, p2, p3);
        dut.dp.mem.mem[0] = p0;
        dut.dp.mem.mem[1] = p1;
        dut.dp.mem.mem[2] = p2;
        dut.dp.mem.mem[3] = p3;
    endtask

    task automatic go();
        reset = 1'b0;
        run   = 1'b1;
    endtask

    initial begin
        vec_t v;
        logic [2:0] ri;
        reset = 1'b1;
        run   = 1'b0;

        //   name        prog words                         data pair 0      data pair 1      cyc pc     ir     cc      h  reg          mem
        add("nop",      16'h0000,16'h0000,16'h0000,16'h0000, -1,16'h0,      -1,16'h0,       5,  16'h1, 16'h0000,3'b010,0, -1,16'h0,    -1,16'h0);
        add("add_imm",  16'h1265,16'h1262,16'h0000,16'h0000, -1,16'h0,      -1,16'h0,       10, 16'h2, 16'h1262,3'b001,0, 1,16'h0007,  -1,16'h0);
        add("and_zero", 16'h1265,16'h1262,16'h5260,16'h0000, -1,16'h0,      -1,16'h0,       15, 16'h3, 16'h5260,3'b010,0, 1,16'h0000,  -1,16'h0);
        add("add_neg",  16'h127F,16'h0000,16'h0000,16'h0000, -1,16'h0,      -1,16'h0,       5,  16'h1, 16'h127F,3'b100,0, 1,16'hFFFF,  -1,16'h0);
        add("not",      16'h927F,16'h0000,16'h0000,16'h0000, -1,16'h0,      -1,16'h0,       5,  16'h1, 16'h927F,3'b100,0, 1,16'hFFFF,  -1,16'h0);
        add("and_reg",  16'h1265,16'h14A3,16'h5642,16'h0000, -1,16'h0,      -1,16'h0,       15, 16'h3, 16'h5642,3'b001,0, 3,16'h0001,  -1,16'h0);
        add("ld",       16'h2402,16'h0000,16'h0000,16'h0000, 3,16'h8000,    -1,16'h0,       7,  16'h1, 16'h2402,3'b100,0, 2,16'h8000,  -1,16'h0);
        add("ld_st",    16'h2402,16'h3405,16'h0000,16'h0000, 3,16'h8000,    -1,16'h0,       14, 16'h2, 16'h3405,3'b100,0, -1,16'h0,    7,16'h8000);
        add("brz",      16'h0404,16'h0000,16'h0000,16'h0000, -1,16'h0,      -1,16'h0,       5,  16'h5, 16'h0404,3'b010,0, -1,16'h0,    -1,16'h0);
        add("brn",      16'h0804,16'h0000,16'h0000,16'h0000, -1,16'h0,      -1,16'h0,       5,  16'h1, 16'h0804,3'b010,0, -1,16'h0,    -1,16'h0);
        add("br_back",  16'h0FFF,16'h0000,16'h0000,16'h0000, -1,16'h0,      -1,16'h0,       5,  16'h0, 16'h0FFF,3'b010,0, -1,16'h0,    -1,16'h0);
        add("lea",      16'hE7FE,16'h0000,16'h0000,16'h0000, -1,16'h0,      -1,16'h0,       5,  16'h1, 16'hE7FE,3'b010,0, 3,16'hFFFF,  -1,16'h0);
        add("jsr",      16'h4805,16'h0000,16'h0000,16'h0000, -1,16'h0,      -1,16'h0,       5,  16'h6, 16'h4805,3'b010,0, 7,16'h0001,  -1,16'h0);
        add("jsrr",     16'h1265,16'h4040,16'h0000,16'h0000, -1,16'h0,      -1,16'h0,       10, 16'h5, 16'h4040,3'b001,0, 7,16'h0002,  -1,16'h0);
        add("jmp",      16'h1265,16'hC040,16'h0000,16'h0000, -1,16'h0,      -1,16'h0,       10, 16'h5, 16'hC040,3'b001,0, 7,16'h0000,  -1,16'h0);
        add("ldi",      16'hA402,16'h0000,16'h0000,16'h0000, 3,16'h0010,    16,16'h1234,    9,  16'h1, 16'hA402,3'b001,0, 2,16'h1234,  -1,16'h0);
        add("sti",      16'h1265,16'hB202,16'h0000,16'h0000, 4,16'h0020,    -1,16'h0,       14, 16'h2, 16'hB202,3'b001,0, -1,16'h0,    32,16'h0005);
        add("ldr",      16'h1265,16'h6443,16'h0000,16'h0000, 8,16'h7FFF,    -1,16'h0,       12, 16'h2, 16'h6443,3'b001,0, 2,16'h7FFF,  -1,16'h0);
        add("str",      16'h1265,16'h7241,16'h0000,16'h0000, -1,16'h0,      -1,16'h0,       12, 16'h2, 16'h7241,3'b001,0, -1,16'h0,    6,16'h0005);
        add("st",       16'h1265,16'h3205,16'h0000,16'h0000, -1,16'h0,      -1,16'h0,       12, 16'h2, 16'h3205,3'b001,0, -1,16'h0,    7,16'h0005);
        add("trap",     16'hF025,16'h0000,16'h0000,16'h0000, -1,16'h0,      -1,16'h0,       24, 16'h1, 16'hF025,3'b010,1, -1,16'h0,    -1,16'h0);
        add("rti",      16'h8000,16'h0000,16'h0000,16'h0000, -1,16'h0,      -1,16'h0,       6,  16'h1, 16'h8000,3'b010,1, -1,16'h0,    -1,16'h0);
        add("rsvd",     16'hD000,16'h0000,16'h0000,16'h0000, -1,16'h0,      -1,16'h0,       6,  16'h1, 16'hD000,3'b010,1, -1,16'h0,    -1,16'h0);

        // Reset state
        hold_reset();
        check("reset_pc", pc_out, 16'h0000);
        check("reset_ir", ir_out, 16'h0000);
        check("reset_cc", {13'b0, cc_out}, 16'h0002);
        check("reset_halted", {15'b0, halted}, 16'h0000);

        foreach (vecs[k]) begin
            v = vecs[k];
            hold_reset();
            load_prog(v.p0, v.p1, v.p2, v.p3);
            if (v.a0 >= 0) dut.dp.mem.mem[16'(v.a0)] = v.v0;
            if (v.a1 >= 0) dut.dp.mem.mem[16'(v.a1)] = v.v1;
            go();
            wait_cycles(v.cycles);
            check({v.name, "_pc"}, pc_out, v.pc);
            check({v.name, "_ir"}, ir_out, v.ir);
            check({v.name, "_cc"}, {13'b0, cc_out}, {13'b0, v.cc});
            check({v.name, "_halted"}, {15'b0, halted}, {15'b0, v.halt});
            if (v.ridx >= 0) begin
                ri = 3'(v.ridx);
                check({v.name, "_reg"}, dut.dp.regs_q[ri], v.rval);
            end
            if (v.maddr >= 0)
                check({v.name, "_mem"}, dut.dp.mem.mem[16'(v.maddr)], v.mval);
        end

        // Back-to-back NOP fetches, with run held low first and again at the end
        hold_reset();
        load_prog(16'h0000, 16'h0001, 16'h0002, 16'h0003);
        reset = 1'b0;
        wait_cycles(3);
        check("run_low_pc", pc_out, 16'h0000);
        run = 1'b1;
        wait_cycles(1);
        check("fetch_pc_first_edge", pc_out, 16'h0001);
        wait_cycles(4);
        check("nop0_ir", ir_out, 16'h0000);
        for (int k = 1; k < 4; k++) begin
            wait_cycles(2);
            check("nop_ir_before_3rd_edge", ir_out, 16'(k - 1));
            wait_cycles(1);
            check("nop_ir_3rd_edge", ir_out, 16'(k));
            wait_cycles(2);
            check("nop_pc", pc_out, 16'(k + 1));
            check("nop_cc", {13'b0, cc_out}, 16'h0002);
        end
        run = 1'b0;
        wait_cycles(5);
        check("run_low_hold_pc", pc_out, 16'h0004);

        // TRAP halts after DECODE, stays put, and a reset pulse clears it asynchronously
        hold_reset();
        load_prog(16'hF025, 16'h0000, 16'h0000, 16'h0000);
        go();
        wait_cycles(3);
        check("trap_decode_halted", {15'b0, halted}, 16'h0000);
        wait_cycles(1);
        check("trap_halted", {15'b0, halted}, 16'h0001);
        wait_cycles(20);
        check("trap_pc_hold", pc_out, 16'h0001);
        reset = 1'b1;
        #1;
        check("trap_reset_pc", pc_out, 16'h0000);
        check("trap_reset_halted", {15'b0, halted}, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(1);
        check("trap_refetch_pc", pc_out, 16'h0001);

        // Reset during FETCH2 of an LD clears everything before the next edge
        hold_reset();
        load_prog(16'h1265, 16'h2402, 16'h0000, 16'h0000);
        dut.dp.mem.mem[3] = 16'h8000;
        go();
        wait_cycles(5);
        check("abort_pre_r1", dut.dp.regs_q[1], 16'h0005);
        wait_cycles(1);
        check("abort_pre_pc", pc_out, 16'h0002);
        reset = 1'b1;
        #1;
        check("abort_ir", ir_out, 16'h0000);
        check("abort_pc", pc_out, 16'h0000);
        check("abort_r1", dut.dp.regs_q[1], 16'h0000);
        check("abort_cc", {13'b0, cc_out}, 16'h0002);
        wait_cycles(2);
        check("abort_r2", dut.dp.regs_q[2], 16'h0000);
        check("abort_hold_pc", pc_out, 16'h0000);

        // Reset during WRITE of a ST drops the pending memory write
        hold_reset();
        load_prog(16'h1265, 16'h3205, 16'h0000, 16'h0000);
        go();
        wait_cycles(11);
        reset = 1'b1;
        #1;
        wait_cycles(1);
        check("dropped_write_mem7", dut.dp.mem.mem[7], 16'h0000);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
